// File: rtl/gtp_lane_supervisor.sv
// Per-lane GTP link supervisor: trains each lane, declares link-up, watches the error rate and can re-reset lanes.
// Optional feature macro GTP_SUP_AUTO_RETRAIN_EN: when defined, a failed lane re-resets itself after one cycle in FAIL.
module gtp_lane_supervisor #(
  parameter int NUM_LANES   = 4,
  parameter int ERR_CNT_W   = 16,
  parameter int UP_CYCLES   = 1024,
  parameter int WIN_CYCLES  = 4096,
  parameter int ERR_THRESH  = 8,
  parameter int HOLD_CYCLES = 256
) (
  input  logic                           clk_gtp,
  input  logic                           rst_gtp_n,
  input  logic [NUM_LANES-1:0]           i_powerdown,
  input  logic [NUM_LANES-1:0]           i_rstdone,
  input  logic [2*NUM_LANES-1:0]         i_los,
  input  logic [2*NUM_LANES-1:0]         i_dpe,
  input  logic [2*NUM_LANES-1:0]         i_nit,
  input  logic [3*NUM_LANES-1:0]         i_bfs,
  input  logic [NUM_LANES-1:0]           i_lane_retrain,
  input  logic                           i_clr_cnt,
  output logic [NUM_LANES-1:0]           o_lane_rst,
  output logic [NUM_LANES-1:0]           o_lane_up,
  output logic [NUM_LANES-1:0]           o_lane_error,
  output logic [NUM_LANES*ERR_CNT_W-1:0] o_err_cnt,
  output logic                           o_all_up,
  output logic                           o_init_done
);

  // One counter per lane is shared by TRAIN (clean run), UP (window) and LRST (hold).
  localparam int CNT_MAX_A = (UP_CYCLES > WIN_CYCLES) ? UP_CYCLES : WIN_CYCLES;
  localparam int CNT_MAX   = (CNT_MAX_A > HOLD_CYCLES) ? CNT_MAX_A : HOLD_CYCLES;
  localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int WERR_W    = $clog2(ERR_THRESH + 1);

  localparam logic [CNT_W-1:0]  UP_LAST   = CNT_W'(UP_CYCLES - 1);
  localparam logic [CNT_W-1:0]  WIN_LAST  = CNT_W'(WIN_CYCLES - 1);
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [WERR_W-1:0] THRESH_V  = WERR_W'(ERR_THRESH);

  typedef enum logic [2:0] {
    ST_OFF, ST_WAIT_RST, ST_TRAIN, ST_UP, ST_FAIL, ST_LRST
  } state_e;

  logic [NUM_LANES-1:0] rst_d, up_d, err_d;
  logic [NUM_LANES-1:0] lane_rst_q, lane_up_q, lane_err_q;
  logic                 all_up_q, init_done_q;
  logic                 unused_bits;

  assign unused_bits = ^{i_los, i_bfs};

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [WERR_W-1:0]     werr_q, werr_d, werr_nx;
    logic [ERR_CNT_W-1:0]  ecnt_q;
    logic                  evt, counting;

    assign evt      = (|i_dpe[2*k +: 2]) | (|i_nit[2*k +: 2]) | i_los[2*k+1] | i_bfs[3*k+2];
    assign counting = (state_q == ST_TRAIN) || (state_q == ST_UP);

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      werr_d  = werr_q;
      werr_nx = werr_q;
      if (i_powerdown[k]) begin
        state_d = ST_OFF;
      end else if (i_lane_retrain[k] && (state_q != ST_OFF) && (state_q != ST_LRST)) begin
        state_d = ST_LRST;
        cnt_d   = '0;
      end else begin
        case (state_q)
          ST_OFF:      state_d = ST_WAIT_RST;
          ST_WAIT_RST: begin
            if (i_rstdone[k]) begin
              state_d = ST_TRAIN;
              cnt_d   = '0;
            end
          end
          ST_TRAIN: begin
            if (!i_rstdone[k]) begin
              state_d = ST_WAIT_RST;
            end else if (evt) begin
              cnt_d = '0;
            end else if (cnt_q == UP_LAST) begin
              state_d = ST_UP;
              cnt_d   = '0;
              werr_d  = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          ST_UP: begin
            // An error on the last cycle of a window opens the next window's count.
            if (cnt_q == WIN_LAST) begin
              cnt_d   = '0;
              werr_nx = WERR_W'(evt);
            end else begin
              cnt_d   = cnt_q + 1'b1;
              werr_nx = werr_q + WERR_W'(evt);
            end
            werr_d = werr_nx;
            if (i_los[2*k+1] || !i_rstdone[k] || (werr_nx == THRESH_V)) state_d = ST_FAIL;
          end
          ST_FAIL: begin
`ifdef GTP_SUP_AUTO_RETRAIN_EN
            state_d = ST_LRST;
            cnt_d   = '0;
`else
            state_d = ST_FAIL;
`endif
          end
          ST_LRST: begin
            if (cnt_q == HOLD_LAST) state_d = ST_WAIT_RST;
            else                    cnt_d   = cnt_q + 1'b1;
          end
          default: state_d = ST_WAIT_RST;
        endcase
      end
    end

    always_ff @(posedge clk_gtp or negedge rst_gtp_n) begin
      if (!rst_gtp_n) begin
        state_q <= ST_WAIT_RST;
        cnt_q   <= '0;
        werr_q  <= '0;
        ecnt_q  <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        werr_q  <= werr_d;
        if (i_clr_cnt)                          ecnt_q <= '0;
        else if (evt && counting && !(&ecnt_q)) ecnt_q <= ecnt_q + 1'b1;
      end
    end

    assign rst_d[k] = (state_d == ST_LRST);
    assign up_d[k]  = (state_d == ST_UP);
    assign err_d[k] = (state_d == ST_FAIL);
    assign o_err_cnt[k*ERR_CNT_W +: ERR_CNT_W] = ecnt_q;
  end

  always_ff @(posedge clk_gtp or negedge rst_gtp_n) begin
    if (!rst_gtp_n) begin
      lane_rst_q  <= '0;
      lane_up_q   <= '0;
      lane_err_q  <= '0;
      all_up_q    <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      lane_rst_q  <= rst_d;
      lane_up_q   <= up_d;
      lane_err_q  <= err_d;
      all_up_q    <= (&(up_d | i_powerdown)) & ~(&i_powerdown);
      init_done_q <= &(i_rstdone | i_powerdown);
    end
  end

  assign o_lane_rst   = lane_rst_q;
  assign o_lane_up    = lane_up_q;
  assign o_lane_error = lane_err_q;
  assign o_all_up     = all_up_q;
  assign o_init_done  = init_done_q;

endmodule

// File: tb/tb_gtp_lane_supervisor.sv
// Directed bench for gtp_lane_supervisor with small timing parameters; expectations are hand-derived edge counts.
module tb_gtp_lane_supervisor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  pd, rstdone, retrain;
  logic [7:0]  los, dpe, nit;
  logic [11:0] bfs;
  logic        clr;
  logic [3:0]  lane_rst, lane_up, lane_err;
  logic [63:0] err_cnt;
  logic        all_up, init_done;

  int checks = 0;
  int errors = 0;

  gtp_lane_supervisor #(
    .NUM_LANES(4), .ERR_CNT_W(16), .UP_CYCLES(16), .WIN_CYCLES(32),
    .ERR_THRESH(3), .HOLD_CYCLES(8)
  ) dut (
    .clk_gtp(clk), .rst_gtp_n(rst_n), .i_powerdown(pd), .i_rstdone(rstdone),
    .i_los(los), .i_dpe(dpe), .i_nit(nit), .i_bfs(bfs), .i_lane_retrain(retrain),
    .i_clr_cnt(clr), .o_lane_rst(lane_rst), .o_lane_up(lane_up), .o_lane_error(lane_err),
    .o_err_cnt(err_cnt), .o_all_up(all_up), .o_init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold_reset();
    rst_n = 1'b0; pd = '0; rstdone = '0; retrain = '0;
    los = '0; dpe = '0; nit = '0; bfs = '0; clr = 1'b0;
    tick(); tick();
  endtask

  // Reset, release with all rstdone high, and wait the 17 edges to reach UP.
  task automatic bringup();
    hold_reset();
    rst_n = 1'b1; rstdone = 4'hF;
    repeat (17) tick();
    checks++; if (lane_up !== 4'hF) begin errors++; $display("FAIL bringup_up got=%h exp=%h", lane_up, 4'hF); end
  endtask

  task automatic test_reset();
    hold_reset();
    rstdone = 4'hF;
    tick();
    checks++; if (lane_rst !== 4'h0) begin errors++; $display("FAIL rst_lane_rst got=%h exp=0", lane_rst); end
    checks++; if (lane_up !== 4'h0) begin errors++; $display("FAIL rst_lane_up got=%h exp=0", lane_up); end
    checks++; if (lane_err !== 4'h0) begin errors++; $display("FAIL rst_lane_err got=%h exp=0", lane_err); end
    checks++; if (err_cnt !== 64'h0) begin errors++; $display("FAIL rst_err_cnt got=%h exp=0", err_cnt); end
    checks++; if ({all_up, init_done} !== 2'b00) begin errors++; $display("FAIL rst_flags got=%b exp=00", {all_up, init_done}); end
    rst_n = 1'b1;
    tick();
    checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL init_done_e1 got=%b exp=1", init_done); end
    checks++; if (lane_up !== 4'h0) begin errors++; $display("FAIL up_e1 got=%h exp=0", lane_up); end
    repeat (15) tick();
    checks++; if (lane_up !== 4'h0) begin errors++; $display("FAIL up_e16 got=%h exp=0", lane_up); end
    tick();
    checks++; if (lane_up !== 4'hF) begin errors++; $display("FAIL up_e17 got=%h exp=F", lane_up); end
    checks++; if (all_up !== 1'b1) begin errors++; $display("FAIL all_up_e17 got=%b exp=1", all_up); end
    rstdone = 4'b0111;
    tick();
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL init_done_partial got=%b exp=0", init_done); end
    pd = 4'b1000;
    tick();
    checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL init_done_pd got=%b exp=1", init_done); end
  endtask

  task automatic test_train_restart();
    hold_reset();
    rst_n = 1'b1; rstdone = 4'hF;
    tick();
    repeat (10) tick();
    dpe = 8'b0000_0100;
    tick();
    dpe = '0;
    checks++; if (err_cnt[31:16] !== 16'd1) begin errors++; $display("FAIL tr_cnt1 got=%0d exp=1", err_cnt[31:16]); end
    checks++; if (err_cnt[15:0] !== 16'd0) begin errors++; $display("FAIL tr_cnt0 got=%0d exp=0", err_cnt[15:0]); end
    repeat (5) tick();
    checks++; if (lane_up !== 4'b1101) begin errors++; $display("FAIL tr_up_e17 got=%b exp=1101", lane_up); end
    checks++; if (all_up !== 1'b0) begin errors++; $display("FAIL tr_all_up_e17 got=%b exp=0", all_up); end
    repeat (10) tick();
    checks++; if (lane_up !== 4'b1101) begin errors++; $display("FAIL tr_up_e27 got=%b exp=1101", lane_up); end
    tick();
    checks++; if (lane_up !== 4'hF) begin errors++; $display("FAIL tr_up_e28 got=%b exp=1111", lane_up); end
    checks++; if (all_up !== 1'b1) begin errors++; $display("FAIL tr_all_up_e28 got=%b exp=1", all_up); end
  endtask

  task automatic test_window_fail();
    bringup();
    dpe = 8'h10;
    tick(); tick();
    checks++; if (lane_err !== 4'h0) begin errors++; $display("FAIL wf_err_two got=%b exp=0000", lane_err); end
    tick();
    dpe = '0;
    checks++; if (lane_err !== 4'b0100) begin errors++; $display("FAIL wf_err_three got=%b exp=0100", lane_err); end
    checks++; if (lane_up !== 4'b1011) begin errors++; $display("FAIL wf_up got=%b exp=1011", lane_up); end
    checks++; if (all_up !== 1'b0) begin errors++; $display("FAIL wf_all_up got=%b exp=0", all_up); end
    checks++; if (err_cnt[47:32] !== 16'd3) begin errors++; $display("FAIL wf_cnt2 got=%0d exp=3", err_cnt[47:32]); end
`ifdef GTP_SUP_AUTO_RETRAIN_EN
    tick();
`else
    repeat (5) tick();
    checks++; if (lane_err !== 4'b0100) begin errors++; $display("FAIL wf_sticky got=%b exp=0100", lane_err); end
    retrain = 4'b0100;
    tick();
    retrain = '0;
`endif
    checks++; if (lane_rst !== 4'b0100) begin errors++; $display("FAIL wf_lrst_on got=%b exp=0100", lane_rst); end
    checks++; if (lane_err !== 4'h0) begin errors++; $display("FAIL wf_err_clr got=%b exp=0000", lane_err); end
    repeat (2) tick();
    retrain = 4'b0100;
    tick();
    retrain = '0;
    repeat (4) tick();
    checks++; if (lane_rst !== 4'b0100) begin errors++; $display("FAIL wf_lrst_last got=%b exp=0100", lane_rst); end
    tick();
    checks++; if (lane_rst !== 4'h0) begin errors++; $display("FAIL wf_lrst_off got=%b exp=0000", lane_rst); end
    repeat (16) tick();
    checks++; if (lane_up !== 4'b1011) begin errors++; $display("FAIL wf_retrain_pre got=%b exp=1011", lane_up); end
    tick();
    checks++; if (lane_up !== 4'hF) begin errors++; $display("FAIL wf_retrain_up got=%b exp=1111", lane_up); end
  endtask

  task automatic test_window_wrap();
    bringup();
    repeat (28) tick();
    nit = 8'h01; tick(); nit = '0;
    bfs = 12'h004; tick(); bfs = '0;
    repeat (3) tick();
    dpe = 8'h02; tick(); dpe = '0;
    nit = 8'h02; tick(); nit = '0;
    checks++; if (lane_err !== 4'h0) begin errors++; $display("FAIL ww_no_fail got=%b exp=0000", lane_err); end
    checks++; if (lane_up !== 4'hF) begin errors++; $display("FAIL ww_up got=%b exp=1111", lane_up); end
    bfs = 12'h004; tick(); bfs = '0;
    checks++; if (lane_err !== 4'b0001) begin errors++; $display("FAIL ww_third got=%b exp=0001", lane_err); end
    checks++; if (err_cnt[15:0] !== 16'd5) begin errors++; $display("FAIL ww_cnt0 got=%0d exp=5", err_cnt[15:0]); end
  endtask

  task automatic test_los();
    bringup();
    los = 8'h08; tick(); los = '0;
    checks++; if (lane_err !== 4'b0010) begin errors++; $display("FAIL los_err got=%b exp=0010", lane_err); end
    checks++; if (lane_up !== 4'b1101) begin errors++; $display("FAIL los_up got=%b exp=1101", lane_up); end
  endtask

  task automatic test_powerdown();
    bringup();
    pd = 4'b1000; tick();
    checks++; if (lane_up !== 4'b0111) begin errors++; $display("FAIL pd_up got=%b exp=0111", lane_up); end
    checks++; if (all_up !== 1'b1) begin errors++; $display("FAIL pd_all_up got=%b exp=1", all_up); end
    pd = 4'hF; tick();
    checks++; if ({lane_up, all_up} !== 5'b0) begin errors++; $display("FAIL pd_all got=%b exp=00000", {lane_up, all_up}); end
    pd = 4'h0; tick(); tick();
    repeat (15) tick();
    checks++; if (lane_up !== 4'h0) begin errors++; $display("FAIL pd_wake_pre got=%b exp=0000", lane_up); end
    tick();
    checks++; if (lane_up !== 4'hF) begin errors++; $display("FAIL pd_wake_up got=%b exp=1111", lane_up); end
  endtask

  task automatic test_async_reset();
    bringup();
    retrain = 4'b0001; tick(); retrain = '0;
    checks++; if (lane_rst !== 4'b0001) begin errors++; $display("FAIL ar_lrst got=%b exp=0001", lane_rst); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (lane_rst !== 4'h0) begin errors++; $display("FAIL ar_lrst_drop got=%b exp=0000", lane_rst); end
    checks++; if (lane_up !== 4'h0) begin errors++; $display("FAIL ar_up_drop got=%b exp=0000", lane_up); end
  endtask

  task automatic test_saturation();
    hold_reset();
    rst_n = 1'b1; rstdone = 4'hF;
    tick();
    dpe = 8'h55;
    repeat (65534) tick();
    checks++; if (err_cnt[15:0] !== 16'hFFFE) begin errors++; $display("FAIL sat_fffe got=%h exp=FFFE", err_cnt[15:0]); end
    tick();
    checks++; if (err_cnt[15:0] !== 16'hFFFF) begin errors++; $display("FAIL sat_ffff got=%h exp=FFFF", err_cnt[15:0]); end
    repeat (3) tick();
    for (int k = 0; k < 4; k++) begin
      checks++; if (err_cnt[16*k +: 16] !== 16'hFFFF) begin errors++; $display("FAIL sat_hold%0d got=%h exp=FFFF", k, err_cnt[16*k +: 16]); end
    end
    clr = 1'b1; tick(); clr = 1'b0;
    checks++; if (err_cnt !== 64'h0) begin errors++; $display("FAIL sat_clr got=%h exp=0", err_cnt); end
    tick();
    checks++; if (err_cnt !== 64'h0001_0001_0001_0001) begin errors++; $display("FAIL sat_recount got=%h exp=0001000100010001", err_cnt); end
    dpe = '0;
  endtask

  initial begin
    test_reset();
    test_train_restart();
    test_window_fail();
    test_window_wrap();
    test_los();
    test_powerdown();
    test_async_reset();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
